// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle trigger requests into output pulses with a guaranteed
// minimum high time and minimum low time, queueing requests that arrive while busy.
module pulse_stretcher #(
  parameter int CLK_PERIOD_NS   = 5,
  parameter int PULSE_TIME_US   = 100,
  parameter int HOLDOFF_TIME_US = 100,
  parameter int PENDING_MAX     = 3,
  localparam int PULSE_CYCLES   = (PULSE_TIME_US * 1000 + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS,
  localparam int HOLDOFF_CYCLES = (HOLDOFF_TIME_US * 1000 + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS,
  localparam int MAX_CYCLES     = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES,
  localparam int CNT_W          = $clog2(MAX_CYCLES + 1),
  localparam int PEND_W         = $clog2(PENDING_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_trig,
  input  logic              i_abort,
  output logic              o_out,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_FULL    = PEND_W'(PENDING_MAX);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_ONE     = PEND_W'(1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PEND_W-1:0]   r_pending;
  logic                r_out;
  logic                r_busy;
  logic                r_overflow;

  state_t              w_nextState;
  logic [CNT_W-1:0]    w_nextCnt;
  logic [PEND_W-1:0]   w_nextPending;
  logic                w_nextOverflow;
  logic                w_enqueue;

  // A request that arrives while a pulse is in progress (and is not served directly by
  // a HOLDOFF exit) either joins the queue or is dropped with an overflow flag.
  always_comb begin
    w_nextState    = r_state;
    w_nextCnt      = r_cnt;
    w_nextPending  = r_pending;
    w_nextOverflow = 1'b0;
    w_enqueue      = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_trig && !i_abort) begin
          w_nextState = ACTIVE;
          w_nextCnt   = '0;
        end
      end

      ACTIVE: begin
        if (i_abort) begin
          w_nextState   = HOLDOFF;
          w_nextCnt     = '0;
          w_nextPending = '0;
        end else begin
          w_enqueue = i_trig;
          if (r_cnt == PULSE_LAST) begin
            w_nextState = HOLDOFF;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_cnt + CNT_ONE;
          end
        end
      end

      HOLDOFF: begin
        if (i_abort) begin
          w_nextPending = '0;
          if (r_cnt == HOLDOFF_LAST) begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_cnt + CNT_ONE;
          end
        end else if (r_cnt == HOLDOFF_LAST) begin
          // A trig on the exit cycle is served together with the dequeue, so it never overflows
          w_nextCnt = '0;
          if (r_pending != '0) begin
            w_nextState   = ACTIVE;
            w_nextPending = i_trig ? r_pending : (r_pending - PEND_ONE);
          end else if (i_trig) begin
            w_nextState = ACTIVE;
          end else begin
            w_nextState = IDLE;
          end
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
          w_enqueue = i_trig;
        end
      end

      default: begin
        w_nextState   = IDLE;
        w_nextCnt     = '0;
        w_nextPending = '0;
      end
    endcase

    if (w_enqueue) begin
      if (r_pending < PEND_FULL) begin
        w_nextPending = r_pending + PEND_ONE;
      end else begin
        w_nextOverflow = 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so out rises one cycle after the trig.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_out      <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      r_pending  <= w_nextPending;
      r_out      <= (w_nextState == ACTIVE);
      r_busy     <= (w_nextState != IDLE);
      r_overflow <= w_nextOverflow;
    end
  end

  assign o_out      = r_out;
  assign o_busy     = r_busy;
  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;

endmodule
